// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Contents:
//   state_t      - FSM state encoding (also exported on state_dbg)
//   OP_*         - primary opcode values (instruction[31:26])
//   ALUOP_*      - ALUop codes, also decoded by the existing ALUControl
//   SRCB_*       - ALUSrcB mux encodings
//   PCSRC_*      - PCSrc mux encodings
//   ctrl_t       - bundle of every datapath control strobe/select
//   is_known_op  - true for opcodes the FSM implements
//   is_half_load - true for lh/lhu
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_RD2      = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_SEXT     = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       load_half;
    logic       load_half_unsigned;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_LH, OP_LHU, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_half_load(input logic [5:0] op);
    return (op == OP_LH) || (op == OP_LHU);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle sequencing FSM for the MIPS datapath. A single memory serves
// instruction fetch and load/store; a single ALU serves PC+4, address and
// branch-target computation. Control outputs are decoded from the current
// state (plus opcode for halfword qualifiers and mem_ready for the fetch
// writes) and forced to zero while reset is high.
//
// Ports:
//   clk, reset        - clock (rising edge), asynchronous active-high reset
//   opcode[5:0]       - instruction[31:26], stable from DECODE to next FETCH
//   mem_ready         - memory completes the current access this cycle
//   IorD..PCSrc       - datapath selects and write enables
//   illegal_op        - one-cycle pulse in DECODE for an unknown opcode
//   state_dbg[3:0]    - current state encoding
//   retired[CNT_W-1:0]- retired-instruction count (wraps)
//
// Memory handshake: while the FSM holds MemRead or MemWrite (FETCH, MEMRD,
// MEMWR) the access is outstanding; it completes in the cycle where
// mem_ready is also high, and only then does the FSM advance. The strobes
// and address select stay constant for the whole wait. mem_ready is ignored
// in every other state.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             LoadHalf,
  output logic             LoadHalfUnsigned,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUop,
  output logic [1:0]       PCSrc,
  output logic             illegal_op,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] retired
);

  state_t state;
  ctrl_t  ctrl;
  ctrl_t  ctrl_out;
  logic   retire;

  // An instruction retires on the transition back to FETCH from its last
  // state. A store only finishes once memory accepts it.
  always_comb begin
    retire = 1'b0;
    case (state)
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: retire = 1'b1;
      S_MEMWR: retire = mem_ready;
      default: retire = 1'b0;
    endcase
  end

  // State register, next-state logic and retire counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      retired <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) state <= S_DECODE;
        end
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_LH, OP_LHU, OP_SW: state <= S_MEMADR;
            OP_RTYPE:                    state <= S_EXEC;
            OP_BEQ:                      state <= S_BRANCH;
            OP_ADDI:                     state <= S_ADDIEX;
            OP_J:                        state <= S_JUMP;
            default:                     state <= S_FETCH;
          endcase
        end
        S_MEMADR: state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD: begin
          if (mem_ready) state <= S_MEMWB;
        end
        S_MEMWB: state <= S_FETCH;
        S_MEMWR: begin
          if (mem_ready) state <= S_FETCH;
        end
        S_EXEC:   state <= S_ALUWB;
        S_ALUWB:  state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_ADDIEX: state <= S_ADDIWB;
        S_ADDIWB: state <= S_FETCH;
        S_JUMP:   state <= S_FETCH;
        // Unused codes 12-15 recover to FETCH.
        default:  state <= S_FETCH;
      endcase

      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // Per-state control decode. Anything not set here stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        // IR and PC only latch on the cycle the read data is valid.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_SEXT_SH2;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = !is_known_op(opcode);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SEXT;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read           = 1'b1;
        ctrl.iord               = 1'b1;
        ctrl.load_half          = is_half_load(opcode);
        ctrl.load_half_unsigned = (opcode == OP_LHU);
      end
      S_MEMWB: begin
        ctrl.mem_to_reg         = 1'b1;
        ctrl.reg_write          = 1'b1;
        ctrl.load_half          = is_half_load(opcode);
        ctrl.load_half_unsigned = (opcode == OP_LHU);
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RD2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RD2;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PCSRC_ALUOUT;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SEXT;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

  // Reset gates the outputs combinationally so strobes drop immediately,
  // without waiting for a clock edge (FETCH would otherwise drive MemRead).
  assign ctrl_out = reset ? '0 : ctrl;

  assign IorD             = ctrl_out.iord;
  assign MemRead          = ctrl_out.mem_read;
  assign MemWrite         = ctrl_out.mem_write;
  assign IRWrite          = ctrl_out.ir_write;
  assign PCWrite          = ctrl_out.pc_write;
  assign PCWriteCond      = ctrl_out.pc_write_cond;
  assign RegDst           = ctrl_out.reg_dst;
  assign MemtoReg         = ctrl_out.mem_to_reg;
  assign RegWrite         = ctrl_out.reg_write;
  assign LoadHalf         = ctrl_out.load_half;
  assign LoadHalfUnsigned = ctrl_out.load_half_unsigned;
  assign ALUSrcA          = ctrl_out.alu_src_a;
  assign ALUSrcB          = ctrl_out.alu_src_b;
  assign ALUop            = ctrl_out.alu_op;
  assign PCSrc            = ctrl_out.pc_src;
  assign illegal_op       = ctrl_out.illegal_op;
  assign state_dbg        = state;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle sequencing FSM for the team's MIPS datapath; successor to the single-cycle control unit.
- Lets one shared memory serve instruction fetch and load/store, and one ALU serve PC increment, address and branch computation.
- Drives the datapath mux selects and write enables per state, stalls on a memory-ready handshake, and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction[31:26] from instruction register; stable from DECODE until return to FETCH.
- mem_ready  in  1  shared memory completes current read/write this cycle.
- IorD  out  1  memory address select: 0 = PC, 1 = ALU result.
- MemRead, MemWrite, IRWrite  out  1 each  memory and IR strobes.
- PCWrite, PCWriteCond  out  1 each  unconditional / branch-if-zero PC update.
- RegDst, MemtoReg, RegWrite  out  1 each  as in single-cycle control.
- LoadHalf, LoadHalfUnsigned  out  1 each  halfword load qualifiers.
- ALUSrcA  out  1  0 = PC, 1 = ReadData1.
- ALUSrcB  out  2  00 = ReadData2, 01 = const 4, 10 = SignExt, 11 = SignExt<<2.
- ALUop  out  3  000 = add, 001 = sub, 010 = use funct.
- PCSrc  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
- illegal_op  out  1  one-cycle pulse on unknown opcode.
- state_dbg  out  4  current state encoding.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: state = FETCH, retired = 0. While reset is high, all outputs are 0. Unlisted outputs are 0 in every state.
- Opcodes: R = 000000, lw = 100011, lh = 100001, lhu = 100101, sw = 101011, beq = 000100, addi = 001000, j = 000010.
- FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUop = add, PCSrc = 00.
  - IRWrite and PCWrite = 1 only when mem_ready = 1, then go to DECODE.
  - Otherwise stay in FETCH with no writes.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUop = add (branch target). Next state by opcode:
  - lw/lh/lhu/sw -> MEMADR; R -> EXEC; beq -> BRANCH; addi -> ADDIEX; j -> JUMP.
  - Any other opcode -> FETCH, illegal_op = 1 this cycle, no retire.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, add. Stores -> MEMWR; loads -> MEMRD.
- MEMRD: MemRead = 1, IorD = 1. Hold until mem_ready, then MEMWB.
- MEMWB: MemtoReg = 1, RegWrite = 1, RegDst = 0 -> FETCH.
- LoadHalf = 1 in MEMRD/MEMWB for lh and lhu; LoadHalfUnsigned = 1 additionally for lhu.
- MEMWR: MemWrite = 1, IorD = 1, held continuously until mem_ready, then FETCH.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUop = 010 -> ALUWB.
- ALUWB: RegDst = 1, RegWrite = 1 -> FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, sub, PCWriteCond = 1, PCSrc = 01 -> FETCH.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10, add -> ADDIWB. ADDIWB: RegWrite = 1, RegDst = 0 -> FETCH.
- JUMP: PCWrite = 1, PCSrc = 10 -> FETCH.
- Retire: retired += 1 on each completing transition into FETCH (from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP). Wraps from all-ones to 0.
- Zero-wait latency in cycles: lw/lh/lhu 5, sw 4, R 4, addi 4, beq 3, j 3. Each mem_ready = 0 cycle in FETCH/MEMRD/MEMWR adds one.
- mem_ready is ignored in states that do not access memory.
- Reset mid-operation, e.g. in MEMWR with mem_ready low: outputs drop to 0 immediately (asynchronous), no retire. FETCH resumes on the first edge after release.
- state_dbg encoding: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11. Codes 12–15 unused; if reached, go to FETCH.

Decomposition:
- Shared package mips_ctrl_pkg holds opcode constants, state encoding, ALUop codes, and ALUSrcB/PCSrc encodings. The existing ALUControl reuses the ALUop codes.
- No sub-module; next-state logic, output decode and counter stay in one module.

Test Plan:
- R-type add with mem_ready tied 1, opcode 000000 -> states 0,1,6,7,0; RegWrite = 1 with RegDst = 1 in cycle 4; retired 0 -> 1.
- lhu with mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; LoadHalf = LoadHalfUnsigned = 1 in states 3 and 4; total 7 cycles.
- sw with mem_ready low 3 cycles in MEMWR -> MemWrite high for exactly 4 consecutive cycles; IorD = 1 throughout; retire once.
- Opcode 111111 -> illegal_op pulses 1 cycle in DECODE; return to FETCH; retired unchanged.
- Reset asserted mid-MEMWR -> MemWrite = 0 before the next clock edge; state_dbg = 0; retired = 0.
- Preload retired to all-ones via 2^CNT_W−1 j instructions (use CNT_W = 4), then one more j -> retired wraps to 0.
